// File: rtl/msg_checker.sv
// Scans the decrypted-message RAM and reports whether every byte is a lowercase letter or space.
// Optional CHECKER_EARLY_ABORT_EN: stop the pass at the first illegal byte.
module msg_checker #(
  parameter int unsigned MESSAGE_LENGTH = 32,
  parameter int unsigned ADDR_WIDTH     = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  finish,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] address,
  input  logic [7:0]            q,
  output logic                  key_ok,
  output logic [7:0]            bad_count,
  output logic [7:0]            first_bad
);

  typedef enum logic [2:0] {StIdle, StRead, StWait, StCheck, StDone} state_e;

  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(MESSAGE_LENGTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  key_ok_q, key_ok_d;
  logic [7:0]            bad_q, bad_d;
  logic [7:0]            first_q, first_d;

  logic byte_legal;
  logic last_byte;
  logic stop_scan;

  assign byte_legal = ((q >= 8'h61) && (q <= 8'h7A)) || (q == 8'h20);
  assign last_byte  = (idx_q == LastIdx);

`ifdef CHECKER_EARLY_ABORT_EN
  assign stop_scan = last_byte || !byte_legal;
`else
  assign stop_scan = last_byte;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    key_ok_d = key_ok_q;
    bad_d    = bad_q;
    first_d  = first_q;
    finish   = 1'b0;
    busy     = 1'b1;
    address  = '0;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          idx_d    = '0;
          bad_d    = 8'd0;
          first_d  = 8'hFF;
          key_ok_d = 1'b0;
          state_d  = StRead;
        end
      end
      StRead: begin
        address = idx_q;
        state_d = StWait;
      end
      StWait: begin
        address = idx_q;
        state_d = StCheck;
      end
      StCheck: begin
        address = idx_q;
        if (!byte_legal) begin
          if (bad_q != 8'hFF) bad_d = bad_q + 8'd1;
          if (first_q == 8'hFF) first_d = 8'(idx_q);
        end
        if (stop_scan) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StRead;
        end
      end
      StDone: begin
        finish   = 1'b1;
        // bad_q already includes the final CHECK's verdict here.
        key_ok_d = (bad_q == 8'd0);
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      key_ok_q <= 1'b0;
      bad_q    <= 8'd0;
      first_q  <= 8'hFF;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      key_ok_q <= key_ok_d;
      bad_q    <= bad_d;
      first_q  <= first_d;
    end
  end

  assign key_ok    = key_ok_q;
  assign bad_count = bad_q;
  assign first_bad = first_q;

endmodule

// File: tb/tb_msg_checker.sv
// Randomized self-checking bench for msg_checker against a byte-rule reference model.
module tb_msg_checker;

  localparam int unsigned N  = 32;
  localparam int unsigned AW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          finish;
  logic          busy;
  logic [AW-1:0] address;
  logic [7:0]    q;
  logic          key_ok;
  logic [7:0]    bad_count;
  logic [7:0]    first_bad;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]    mem [N];
  logic [AW-1:0] addr_r;

  msg_checker #(
    .MESSAGE_LENGTH(N),
    .ADDR_WIDTH    (AW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .finish   (finish),
    .busy     (busy),
    .address  (address),
    .q        (q),
    .key_ok   (key_ok),
    .bad_count(bad_count),
    .first_bad(first_bad)
  );

  always #5 clock = ~clock;

  // Synchronous RAM: address registered, data valid one cycle later.
  always @(posedge clock) begin
    addr_r <= address;
    q      <= mem[addr_r];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
  endfunction

  // Expected tally, first bad index and finish cycle (relative to E0) for current mem.
  task automatic model(output int bad, output int fb, output int d);
    bad = 0;
    fb  = 255;
    d   = 3 * N + 1;
    for (int i = 0; i < N; i++) begin
      if (!is_legal(mem[i])) begin
        if (bad < 255) bad++;
        if (fb == 255) fb = i;
`ifdef CHECKER_EARLY_ABORT_EN
        d = 3 * (i + 1) + 1;
        break;
`endif
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, ".finish"}, finish, 0);
    check_eq({tag, ".busy"}, busy, 0);
    check_eq({tag, ".address"}, address, 0);
    check_eq({tag, ".key_ok"}, key_ok, 0);
    check_eq({tag, ".bad_count"}, bad_count, 0);
    check_eq({tag, ".first_bad"}, first_bad, 8'hFF);
  endtask

  // Pulse start, follow the pass cycle by cycle, then check the verdict.
  task automatic run_pass(input string tag, input bit noisy);
    int bad, fb, d;
    model(bad, fb, d);
    start = 1'b1;
    for (int c = 1; c <= d + 1; c++) begin
      tick();
      start = (noisy && c < d) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (c <= d) begin
        check_eq({tag, ".busy"}, busy, 1);
        check_eq({tag, ".finish"}, finish, (c == d));
        check_eq({tag, ".address"}, address, (c < d) ? (c - 1) / 3 : 0);
      end else begin
        check_eq({tag, ".busy_end"}, busy, 0);
        check_eq({tag, ".finish_end"}, finish, 0);
        check_eq({tag, ".address_end"}, address, 0);
        check_eq({tag, ".key_ok"}, key_ok, (bad == 0));
        check_eq({tag, ".bad_count"}, bad_count, bad);
        check_eq({tag, ".first_bad"}, first_bad, fb);
      end
    end
  endtask

  task automatic fill_all(input logic [7:0] b);
    for (int i = 0; i < N; i++) mem[i] = b;
  endtask

  task automatic fill_random();
    int r;
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        mem[i] = 8'($urandom);
      end else begin
        r = $urandom_range(0, 26);
        mem[i] = (r == 26) ? 8'h20 : 8'(8'h61 + r);
      end
    end
  endtask

  initial begin
    int bad, fb, d;
    bit done;
    logic [7:0] bnd [7];
    bnd = '{8'h60, 8'h61, 8'h7A, 8'h7B, 8'h1F, 8'h20, 8'h21};

    reset = 1'b1;
    start = 1'b0;
    fill_all(8'h61);
    tick();
    tick();
    reset = 1'b0;
    check_reset_vals("reset");
    tick();

    run_pass("all_a", 1'b0);

    fill_all(8'h20);
    mem[5] = 8'h7B;
    run_pass("byte5", 1'b0);

    fill_all(8'h61);
    for (int i = 0; i < 7; i++) mem[i] = bnd[i];
    run_pass("boundary", 1'b0);

    for (int k = 0; k < 6; k++) begin
      fill_random();
      run_pass("random", 1'b1);
      tick();
    end

    // Reset in cycle 40 of a pass: no finish, reset values next cycle.
    fill_all(8'h61);
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      start = 1'b0;
      check_eq("abort.finish", finish, 0);
      if (c == 40) reset = 1'b1;
    end
    tick();
    reset = 1'b0;
    check_reset_vals("abort");
    for (int c = 0; c < 5; c++) begin
      tick();
      check_eq("abort.quiet_finish", finish, 0);
      check_eq("abort.quiet_busy", busy, 0);
    end
    run_pass("after_abort", 1'b0);

    // Start held high: back-to-back passes.
    fill_all(8'h61);
    model(bad, fb, d);
    start = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      tick();
      check_eq("hold.finish", finish, (c == d) || (c == 2 * d + 1));
    end
    start = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      tick();
      if (!busy) done = 1'b1;
    end
    check_eq("hold.drain", done, 1);
    check_eq("hold.key_ok", key_ok, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/msg_checker.md
# msg_checker

Reads the decrypted-message RAM after the decrypt task finishes. It checks that every byte is a lowercase ASCII letter or a space, and reports whether the current secret key produced readable plaintext. It is the read side of the decrypted-message RAM: the decrypt task writes it, this block reads it. The controller FSM uses its verdict to accept the key or step to the next candidate. It follows the codebase start/finish handshake, and its bus outputs are ORed with other tasks onto shared memory ports.

## Interface
- MESSAGE_LENGTH, default 32: number of bytes checked; legal range 1..255.
- ADDR_WIDTH, default 8: RAM address width.
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a check pass; sampled only in IDLE.
- finish  out  1  one-cycle pulse when the pass completes.
- busy  out  1  high in every state except IDLE.
- address  out  ADDR_WIDTH  decrypted-RAM read address; 0 whenever not reading, so it is OR-safe on the shared bus.
- q  in  8  decrypted-RAM read data; synchronous RAM, valid one cycle after the address is registered.
- key_ok  out  1  1 = every checked byte was legal; held until the next start.
- bad_count  out  8  count of illegal bytes, saturating at 255.
- first_bad  out  8  index of the first illegal byte; 8'hFF if none.

## Operation
- Legal byte: 8'h61..8'h7A inclusive, or 8'h20. Every other value is illegal, including 8'h60, 8'h7B and 8'h00.
- States:
  - IDLE: wait for start = 1. On start: idx <= 0, bad_count <= 0, first_bad <= 8'hFF, key_ok <= 0; go to READ.
  - READ: address = idx; go to WAIT.
  - WAIT: address held; go to CHECK.
  - CHECK: address held; classify q.
    - If illegal: bad_count increments, saturating at 255. If first_bad == 8'hFF, first_bad <= idx.
    - If idx == MESSAGE_LENGTH-1, go to DONE. Otherwise idx <= idx+1 and go to READ.
  - DONE: finish = 1; key_ok <= (bad_count == 0), counting any illegal byte from the final CHECK. Go to IDLE.
- address is 0 in IDLE and DONE.
- The block never asserts a write enable.
- start is ignored in every state except IDLE.
- If start is still high when the FSM returns to IDLE, a new pass begins on the next edge and clears all results.
- idx is ADDR_WIDTH bits wide. It never wraps, because MESSAGE_LENGTH ≤ 255.

## Timing
- Reset values: finish=0, busy=0, address=0, key_ok=0, bad_count=0, first_bad=8'hFF; state=IDLE. Reset also clears idx.
- Reset asserted mid-pass: all outputs take their reset values on the next edge. No finish pulse is emitted for the aborted pass.
- Let E0 be the edge at which start is sampled in IDLE.
- Byte i occupies the three cycles after E0 + 3i: READ, then WAIT, then CHECK.
- Full pass: DONE, and therefore finish, is high during cycle 3·MESSAGE_LENGTH+1 after E0. For the default length that is cycle 97.
- key_ok, bad_count and first_bad are final and stable from the cycle after DONE. They hold until the next E0.
- busy is high from the cycle after E0 through DONE inclusive.

## Configuration
- CHECKER_EARLY_ABORT_EN defined:
  - A CHECK that finds an illegal byte goes straight to DONE. bad_count is then 1 and first_bad is that index.
  - Pass length is 3·(first_bad+1)+1 cycles, which speeds up key search.
- Undefined: every byte is always scanned and bad_count reports the full tally.

## Test plan
- RAM holds 32 × 8'h61; pulse start → finish at cycle 97 after E0; key_ok=1, bad_count=0, first_bad=8'hFF.
- Byte 5 = 8'h7B, rest 8'h20 → key_ok=0, first_bad=5.
  - Macro undefined: bad_count=1, finish at cycle 97.
  - Macro defined: finish at cycle 19.
- Boundary bytes 8'h60, 8'h61, 8'h7A, 8'h7B, 8'h1F, 8'h20, 8'h21 at indices 0..6, macro undefined → bad_count=4, first_bad=0.
- Assert reset at cycle 40 mid-pass → next cycle all outputs at reset values, address=0; no finish pulse; a later start runs a clean pass.
- Hold start high for 200 cycles on an all-legal RAM → back-to-back passes, finish at cycles 97 and 195; start pulses while busy have no effect.
- Monitor address over a full pass → nonzero only in READ/WAIT/CHECK and equal to idx there; always 0 in IDLE and DONE.
